// File: rtl/exp3_unidade_controle_jogo.sv
// Game controller for the 16-position memory-check datapath.
// Waits for a start request, then for each address waits for a player move
// (rising edge of jogada), loads the switches, checks the comparator and
// either advances the address counter or ends the round. A round ends in
// fim_acerto (all 16 correct), fim_erro (mismatch) or fim_timeout (no move
// within TIMEOUT cycles).
//
// Ports:
//   clock              system clock, rising edge
//   reset_n            asynchronous reset, active-low
//   iniciar            start / restart request (level)
//   jogada             move indication (OR of switches), edge-detected here
//   chavesIgualMemoria comparator equal flag from the datapath
//   fimC               address counter terminal count (address == 15)
//   zeraC / contaC     address counter clear / enable
//   zeraR / registraR  switch register clear / load
//   pronto             any final state
//   acertou/errou/timeout  which final state
//   db_estado          current state encoding
module exp3_unidade_controle_jogo #(
  parameter int unsigned TIMEOUT = 3000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       chavesIgualMemoria,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    ST_INICIAL     = 4'h0,
    ST_PREPARACAO  = 4'h1,
    ST_ESPERA      = 4'h2,
    ST_REGISTRA    = 4'h4,
    ST_COMPARACAO  = 4'h5,
    ST_PROXIMO     = 4'h6,
    ST_FIM_ACERTO  = 4'hA,
    ST_FIM_TIMEOUT = 4'hD,
    ST_FIM_ERRO    = 4'hE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_jogada_d;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rise;
  logic             w_tmo;

  // Registered Moore outputs, loaded from the decode of the next state so
  // they always match the state register.
  logic r_zera_c, r_conta_c, r_zera_r, r_registra_r;
  logic r_pronto, r_acertou, r_errou, r_timeout;
  logic w_zera_c, w_conta_c, w_zera_r, w_registra_r;
  logic w_pronto, w_acertou, w_errou, w_timeout;

  assign w_rise = jogada & ~r_jogada_d;
  assign w_tmo  = (r_cnt == CNT_LAST);

  // Next-state logic and output decode of the next state.
  always_comb begin
    w_next       = r_state;
    w_zera_c     = 1'b0;
    w_conta_c    = 1'b0;
    w_zera_r     = 1'b0;
    w_registra_r = 1'b0;
    w_pronto     = 1'b0;
    w_acertou    = 1'b0;
    w_errou      = 1'b0;
    w_timeout    = 1'b0;

    case (r_state)
      ST_INICIAL:    if (iniciar) w_next = ST_PREPARACAO;
      ST_PREPARACAO: w_next = ST_ESPERA;
      ST_ESPERA: begin
        // A move on the last allowed cycle wins over the timeout.
        if (w_rise)     w_next = ST_REGISTRA;
        else if (w_tmo) w_next = ST_FIM_TIMEOUT;
      end
      ST_REGISTRA:   w_next = ST_COMPARACAO;
      ST_COMPARACAO: begin
        if (!chavesIgualMemoria) w_next = ST_FIM_ERRO;
        else if (fimC)           w_next = ST_FIM_ACERTO;
        else                     w_next = ST_PROXIMO;
      end
      ST_PROXIMO:    w_next = ST_ESPERA;
      ST_FIM_ACERTO,
      ST_FIM_ERRO,
      ST_FIM_TIMEOUT: if (iniciar) w_next = ST_PREPARACAO;
      default:       w_next = ST_INICIAL;
    endcase

    case (w_next)
      ST_INICIAL, ST_PREPARACAO: begin
        w_zera_c = 1'b1;
        w_zera_r = 1'b1;
      end
      ST_REGISTRA:   w_registra_r = 1'b1;
      ST_PROXIMO:    w_conta_c    = 1'b1;
      ST_FIM_ACERTO: begin
        w_pronto  = 1'b1;
        w_acertou = 1'b1;
      end
      ST_FIM_ERRO: begin
        w_pronto = 1'b1;
        w_errou  = 1'b1;
      end
      ST_FIM_TIMEOUT: begin
        w_pronto  = 1'b1;
        w_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  // State, output and edge-detect registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_INICIAL;
      r_jogada_d   <= 1'b0;
      r_zera_c     <= 1'b1;
      r_conta_c    <= 1'b0;
      r_zera_r     <= 1'b1;
      r_registra_r <= 1'b0;
      r_pronto     <= 1'b0;
      r_acertou    <= 1'b0;
      r_errou      <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_jogada_d   <= jogada;
      r_zera_c     <= w_zera_c;
      r_conta_c    <= w_conta_c;
      r_zera_r     <= w_zera_r;
      r_registra_r <= w_registra_r;
      r_pronto     <= w_pronto;
      r_acertou    <= w_acertou;
      r_errou      <= w_errou;
      r_timeout    <= w_timeout;
    end
  end

  // Cycles spent in espera_jogada; saturates instead of wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_state != ST_ESPERA) begin
      r_cnt <= '0;
    end else if (!w_tmo) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign zeraC     = r_zera_c;
  assign contaC    = r_conta_c;
  assign zeraR     = r_zera_r;
  assign registraR = r_registra_r;
  assign pronto    = r_pronto;
  assign acertou   = r_acertou;
  assign errou     = r_errou;
  assign timeout   = r_timeout;
  assign db_estado = r_state;

endmodule

// File: tb/tb_exp3_unidade_controle_jogo.sv
// Randomized bench for the game controller. A small datapath model (address
// counter, one-cycle ROM, switch register, comparator) surrounds the DUT.
// Each round is described by memory contents, the values played and the
// cycle on which each move is pressed; a reference model derives the round
// outcome from the game rules and queues it for the monitor.
module tb_exp3_unidade_controle_jogo;

  localparam int unsigned TO = 8;
  localparam int S_PREP = 1, S_ESP = 2, S_ACE = 10, S_TMO = 13, S_ERR = 14;

  logic       clock, reset_n, iniciar, jogada, chaves, fimC;
  logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  logic [3:0] sw, r_addr, r_rom, r_reg;
  logic [3:0] mem [16];

  int checks, errors;

  typedef struct packed {
    logic [3:0] st;
    logic       ac;
    logic       er;
    logic       to;
    int         conta;
    int         regs;
    int         dwell;
  } exp_t;
  exp_t exp_q[$];

  int         cur_k;
  logic [3:0] cur_val [16];
  int         cur_d [16];
  int         cur_p [16];
  int         cur_h [16];
  bit         cur_held [16];

  exp3_unidade_controle_jogo #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .jogada(jogada),
    .chavesIgualMemoria(chaves), .fimC(fimC),
    .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
    .db_estado(db_estado)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Datapath model.
  assign jogada = |sw;
  assign fimC   = (r_addr == 4'd15);
  assign chaves = (r_reg == r_rom);

  always_ff @(posedge clock) begin
    if (zeraC)       r_addr <= 4'd0;
    else if (contaC) r_addr <= r_addr + 4'd1;
    r_rom <= mem[r_addr];
    if (zeraR)          r_reg <= 4'd0;
    else if (registraR) r_reg <= sw;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Outcome of the current round from the game rules.
  function automatic exp_t model_round();
    exp_t e;
    bit   done;
    e = '0;
    done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!done) begin
        if (i >= cur_k) begin
          e.st = 4'hD; e.to = 1'b1; e.dwell = int'(TO); done = 1'b1;
        end else begin
          e.regs++;
          if (cur_val[i] != mem[i]) begin
            e.st = 4'hE; e.er = 1'b1; e.dwell = cur_d[i] + 1; done = 1'b1;
          end else if (i == 15) begin
            e.st = 4'hA; e.ac = 1'b1; e.dwell = cur_d[i] + 1; done = 1'b1;
          end else begin
            e.conta++;
          end
        end
      end
    end
    return e;
  endfunction

  // kind 0: all correct; 1: wrong value at index param; 2: stop after param moves.
  task automatic gen_round(input int kind, input int param, input bit collide);
    logic [3:0] v;
    for (int i = 0; i < 16; i++) begin
      mem[i]      = 4'($urandom_range(15, 1));
      cur_val[i]  = mem[i];
      cur_h[i]    = int'($urandom_range(3, 2));
      cur_held[i] = (i > 0) && ($urandom_range(3, 0) == 0) && !collide;
      if (cur_held[i]) begin
        cur_p[i] = int'($urandom_range(TO - 2, 0));
        cur_d[i] = cur_p[i] + int'($urandom_range(TO - 1 - cur_p[i], 1));
      end else begin
        cur_p[i] = 0;
        cur_d[i] = collide ? int'(TO - 1) : int'($urandom_range(TO - 1, 0));
      end
    end
    case (kind)
      0: cur_k = 16;
      1: begin
        cur_k = param + 1;
        v = mem[param];
        while (v == mem[param]) v = 4'($urandom_range(15, 1));
        cur_val[param] = v;
      end
      default: cur_k = param;
    endcase
  endtask

  task automatic wait_espera(output bit ok);
    int n = 0;
    while (int'(db_estado) != S_ESP && n < 40) begin
      @(negedge clock);
      n++;
    end
    ok = (int'(db_estado) == S_ESP);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_espera: state %0h after %0d cycles, required 2", db_estado, n);
    end
  endtask

  task automatic wait_final(output bit ok);
    int n = 0;
    while (!pronto && n < 100) begin
      @(negedge clock);
      n++;
    end
    ok = pronto;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_final: pronto 0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic recover();
    exp_q.delete();
    sw = 4'd0;
    iniciar = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Plays the current round; abort_after >= 0 resets the DUT mid-round.
  task automatic run_round(input int abort_after);
    bit ok;
    int n_moves;
    ok = 1'b1;
    n_moves = (abort_after >= 0) ? abort_after : cur_k;
    if (abort_after < 0) exp_q.push_back(model_round());
    @(negedge clock); iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    for (int i = 0; i < n_moves; i++) begin
      if (ok) begin
        wait_espera(ok);
        if (ok) begin
          if (cur_held[i]) begin
            repeat (cur_p[i]) @(negedge clock);
            sw = 4'd0;
            repeat (cur_d[i] - cur_p[i]) @(negedge clock);
          end else begin
            repeat (cur_d[i]) @(negedge clock);
          end
          sw = cur_val[i];
          if (i + 1 < cur_k && cur_held[i + 1]) begin
            @(negedge clock);
          end else begin
            repeat (cur_h[i]) @(negedge clock);
            sw = 4'd0;
          end
        end
      end
    end
    if (ok && abort_after >= 0) begin
      repeat (2) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_db_estado", int'(db_estado), 0);
      chk("rst_zeraC", int'(zeraC), 1);
      chk("rst_zeraR", int'(zeraR), 1);
      chk("rst_pronto", int'(pronto), 0);
      sw = 4'd0;
      @(negedge clock);
      reset_n = 1'b1;
    end else if (ok) begin
      wait_final(ok);
    end
    if (!ok) recover();
    repeat (2) @(negedge clock);
  endtask

  // Monitor: tracks strobes per round and checks each round outcome.
  initial begin
    int   prev_st, conta_n, reg_n, run, last_run;
    logic prev_pr;
    exp_t e;
    prev_st = 0; prev_pr = 1'b0; conta_n = 0; reg_n = 0; run = 0; last_run = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_st = 0; prev_pr = 1'b0; run = 0;
      end else begin
        if (prev_st == S_PREP) chk("prep_next_state", int'(db_estado), S_ESP);
        if (int'(db_estado) == S_PREP) begin
          chk("prep_zeraC", int'(zeraC), 1);
          chk("prep_zeraR", int'(zeraR), 1);
          conta_n = 0;
          reg_n = 0;
        end
        conta_n += int'(contaC);
        reg_n   += int'(registraR);
        if (int'(db_estado) == S_ESP) begin
          run++;
        end else if (run > 0) begin
          last_run = run;
          run = 0;
        end
        if (pronto && !prev_pr) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_final: state %0h, no round expected", db_estado);
          end else begin
            e = exp_q.pop_front();
            chk("final_state", int'(db_estado), int'(e.st));
            chk("acertou", int'(acertou), int'(e.ac));
            chk("errou", int'(errou), int'(e.er));
            chk("timeout", int'(timeout), int'(e.to));
            chk("contaC_cycles", conta_n, e.conta);
            chk("registraR_cycles", reg_n, e.regs);
            chk("last_espera_dwell", last_run, e.dwell);
          end
        end
        prev_st = int'(db_estado);
        prev_pr = pronto;
      end
    end
  end

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; iniciar = 1'b0; sw = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 4'd1;
    repeat (2) @(negedge clock);
    chk("reset_db_estado", int'(db_estado), 0);
    chk("reset_zeraC", int'(zeraC), 1);
    chk("reset_zeraR", int'(zeraR), 1);
    chk("reset_pronto", int'(pronto), 0);
    chk("reset_contaC", int'(contaC), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    gen_round(0, 0, 1'b0);  run_round(-1);   // happy path
    gen_round(1, 2, 1'b0);  run_round(-1);   // mismatch on 3rd compare
    gen_round(2, 0, 1'b0);  run_round(-1);   // immediate timeout, restart from fim_erro
    gen_round(1, 4, 1'b1);  run_round(-1);   // every move on the last allowed cycle
    gen_round(0, 0, 1'b1);  run_round(-1);
    gen_round(2, 3, 1'b0);  run_round(-1);   // timeout after 3 moves
    gen_round(0, 0, 1'b0);  run_round(3);    // async reset mid-round
    for (int r = 0; r < 10; r++) begin
      int kind;
      kind = int'($urandom_range(2, 0));
      gen_round(kind, int'($urandom_range(15, 0)), ($urandom_range(4, 0) == 0));
      run_round(-1);
    end

    repeat (4) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exp3_unidade_controle_jogo.md
Name: exp3_unidade_controle_jogo

Overview:
- FSM controller that sequences the 16-position memory-check datapath (counter, sync ROM, 4-bit register, comparator).
- Waits for a start pulse, then for each address:
  - waits for a player move (rising edge of jogada);
  - registers the switches and compares them with memory;
  - advances or ends the round.
- Ends in one of three states: all 16 correct (acertou), mismatch (errou), or no move within TIMEOUT cycles (timeout).

Parameters:
- TIMEOUT, 3000, clock cycles allowed in espera_jogada before timeout; legal range 2..65535.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous reset, active-low
- iniciar  input  1  start request, level sampled each cycle
- jogada  input  1  move indication (OR of switches); controller edge-detects internally
- chavesIgualMemoria  input  1  comparator equal output from datapath
- fimC  input  1  counter rco (address == 15)
- zeraC  output  1  clear counter (datapath active-high)
- contaC  output  1  counter enable
- zeraR  output  1  clear register
- registraR  output  1  register load enable
- pronto  output  1  high in any final state
- acertou  output  1  high in fim_acerto
- errou  output  1  high in fim_erro
- timeout  output  1  high in fim_timeout
- db_estado  output  4  current state encoding

Behaviour:
- Reset is asynchronous, active-low. On reset_n=0:
  - state goes to inicial;
  - the jogada edge register and the timeout counter clear.
- All outputs are Moore, decoded from the state register only. Reset values: zeraC=1, zeraR=1, all other outputs 0, db_estado=0.
- Edge detect: jogada_d is jogada registered every cycle. jogada_rise = jogada & ~jogada_d.
- States, with encoding and outputs:
  - inicial (0x0): zeraC=1, zeraR=1. Goes to preparacao when iniciar=1, else stays.
  - preparacao (0x1): zeraC=1, zeraR=1. Always goes to espera_jogada.
  - espera_jogada (0x2): no datapath strobes. Goes to registra on jogada_rise. Goes to fim_timeout when the timeout counter reaches TIMEOUT-1 with no rise. Otherwise stays.
  - registra (0x4): registraR=1. Always goes to comparacao.
  - comparacao (0x5): no strobes.
    - chavesIgualMemoria=0: go to fim_erro.
    - chavesIgualMemoria=1 and fimC=1: go to fim_acerto.
    - chavesIgualMemoria=1 and fimC=0: go to proximo.
  - proximo (0x6): contaC=1. Always goes to espera_jogada.
  - fim_acerto (0xA): pronto=1, acertou=1.
  - fim_erro (0xE): pronto=1, errou=1.
  - fim_timeout (0xD): pronto=1, timeout=1.
  - From any final state: iniciar=1 goes to preparacao (restart); otherwise stay.
  - Unused encodings go to inicial.
- Timeout counter:
  - clears in every state other than espera_jogada;
  - increments each cycle in espera_jogada;
  - width is ceil(log2(TIMEOUT)) bits and it never wraps.
  - Timeout fires exactly TIMEOUT cycles after entering espera_jogada, counting the entry cycle as cycle 0.
- Simultaneous events in espera_jogada: jogada_rise on the same cycle the counter reaches TIMEOUT-1 goes to registra; the move wins.
- Rise filtering:
  - jogada already high when espera_jogada is entered does not count; the switch must be released and pressed again.
  - A rise in any other state is ignored and is not queued.
- ROM latency: the sync ROM updates one clock after the counter changes. proximo followed by at least one cycle in espera_jogada guarantees valid data by comparacao. The comparison uses the register value loaded on the registra exit edge.
- Per-move latency is rise-to-compare-decision 3 cycles: espera, then registra, then comparacao.
- Reset mid-round: immediate return to inicial. The counter and register are then cleared via zeraC and zeraR on the next edge.

Test Plan:
- Reset with reset_n=0 mid-round, async (no clock edge) -> db_estado=0x0, zeraC=1, zeraR=1, pronto=0 immediately.
- Happy path: iniciar pulse, then 16 jogada rises with chavesIgualMemoria=1 and fimC asserted only on the 16th compare -> exactly 15 contaC pulses, 16 registraR pulses, then fim_acerto with db_estado=0xA, acertou=1, pronto=1.
- Mismatch: chavesIgualMemoria=0 on the 3rd compare -> fim_erro (0xE), errou=1, exactly 2 contaC pulses issued.
- Timeout with TIMEOUT=8: no jogada after entering espera_jogada -> fim_timeout (0xD) 8 cycles later, timeout=1.
- Held switch: jogada=1 held from before espera_jogada entry -> no registraR. Then release and re-press -> registraR high for exactly 1 cycle.
- Collision plus restart: jogada rise on the TIMEOUT-1 cycle -> registra, not timeout. In fim_erro, iniciar=1 -> preparacao (0x1) with zeraC=zeraR=1, then espera_jogada.
